dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 50 +++++
 rtl/dmem_arbiter.sv | 111 +++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Core, host and data-memory signal bundle around the dmem arbiter.
// The arbiter takes the slave side; requesters and memory take the master side.
interface dmem_arbiter_if #(
    parameter int W = 8,
    parameter int A = 8
);
    logic         C_Req;
    logic         C_We;
    logic [A-1:0] C_Addr;
    logic [W-1:0] C_WData;
    logic         C_Gnt;
    logic [W-1:0] C_RData;
    logic         C_RValid;

    logic         H_Req;
    logic         H_We;
    logic         H_Lock;
    logic [A-1:0] H_Addr;
    logic [W-1:0] H_WData;
    logic         H_Gnt;
    logic [W-1:0] H_RData;
    logic         H_RValid;

    logic [A-1:0] Mem_Addr;
    logic         Mem_WrEn;
    logic [W-1:0] Mem_DataIn;
    logic [W-1:0] Mem_DataOut;

    logic         Core_Stall;

    modport slave (
        input  C_Req, C_We, C_Addr, C_WData,
        input  H_Req, H_We, H_Lock, H_Addr, H_WData,
        input  Mem_DataOut,
        output C_Gnt, C_RData, C_RValid,
        output H_Gnt, H_RData, H_RValid,
        output Mem_Addr, Mem_WrEn, Mem_DataIn,
        output Core_Stall
    );

    modport master (
        output C_Req, C_We, C_Addr, C_WData,
        output H_Req, H_We, H_Lock, H_Addr, H_WData,
        output Mem_DataOut,
        input  C_Gnt, C_RData, C_RValid,
        input  H_Gnt, H_RData, H_RValid,
        input  Mem_Addr, Mem_WrEn, Mem_DataIn,
        input  Core_Stall
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin between core and host, with a
// bounded host burst lock so the core is never starved beyond MAXBURST cycles.
module dmem_arbiter #(
    parameter int W        = 8,
    parameter int A        = 8,
    parameter int MAXBURST = 16
) (
    input  logic          Clk,
    input  logic          Reset_n,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CORE, HOST, HLOCK} state_t;

    localparam logic [7:0] maxBc = 8'(MAXBURST);

    state_t       stateReg, stateNext;
    logic [7:0]   bcReg, bcNext;
    logic         runReg;
    logic         cGnt, hGnt;
    logic [A-1:0] addrReg, addrNext;
    logic [W-1:0] dataReg, dataNext;
    logic         cRValidReg, hRValidReg;
    logic [W-1:0] cRDataReg, hRDataReg;

    // runReg keeps requests masked until the first edge after reset release.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            runReg     <= 1'b0;
            stateReg   <= IDLE;
            bcReg      <= '0;
            addrReg    <= '0;
            dataReg    <= '0;
            cRValidReg <= 1'b0;
            hRValidReg <= 1'b0;
            cRDataReg  <= '0;
            hRDataReg  <= '0;
        end else begin
            runReg     <= 1'b1;
            stateReg   <= stateNext;
            bcReg      <= bcNext;
            addrReg    <= addrNext;
            dataReg    <= dataNext;
            cRValidReg <= cGnt & ~bus.C_We;
            hRValidReg <= hGnt & ~bus.H_We;
            if (cGnt && !bus.C_We)
                cRDataReg <= bus.Mem_DataOut;
            if (hGnt && !bus.H_We)
                hRDataReg <= bus.Mem_DataOut;
        end
    end

    always_comb begin
        stateNext = stateReg;
        bcNext    = bcReg;
        cGnt      = 1'b0;
        hGnt      = 1'b0;
        if (runReg) begin
            if (stateReg == HLOCK && bus.H_Req && bus.H_Lock) begin
                // A full burst yields exactly one slot to a waiting core.
                if (bcReg >= maxBc && bus.C_Req)
                    cGnt = 1'b1;
                else
                    hGnt = 1'b1;
            end else if (bus.C_Req && bus.H_Req) begin
                if (stateReg == CORE)
                    hGnt = 1'b1;
                else
                    cGnt = 1'b1;
            end else begin
                cGnt = bus.C_Req;
                hGnt = bus.H_Req;
            end

            // Dropping the lock leaves the host as the most recent owner.
            if (stateReg == HLOCK && !(bus.H_Req && bus.H_Lock)) begin
                stateNext = HOST;
                bcNext    = '0;
            end

            if (cGnt) begin
                stateNext = CORE;
                bcNext    = '0;
            end else if (hGnt && bus.H_Lock) begin
                stateNext = HLOCK;
                if (stateReg != HLOCK)
                    bcNext = 8'd1;
                else if (bcReg < maxBc)
                    bcNext = bcReg + 8'd1;
            end else if (hGnt) begin
                stateNext = HOST;
                bcNext    = '0;
            end
        end
    end

    // Memory address and write data hold their last driven value between grants.
    assign addrNext = cGnt ? bus.C_Addr  : (hGnt ? bus.H_Addr  : addrReg);
    assign dataNext = cGnt ? bus.C_WData : (hGnt ? bus.H_WData : dataReg);

    assign bus.Mem_Addr   = addrNext;
    assign bus.Mem_DataIn = dataNext;
    assign bus.Mem_WrEn   = (cGnt & bus.C_We) | (hGnt & bus.H_We);

    assign bus.C_Gnt      = cGnt;
    assign bus.H_Gnt      = hGnt;
    assign bus.C_RValid   = cRValidReg;
    assign bus.H_RValid   = hRValidReg;
    assign bus.C_RData    = cRDataReg;
    assign bus.H_RData    = hRDataReg;
    assign bus.Core_Stall = Reset_n & bus.C_Req & ~cGnt;
endmodule
